// File: rtl/dma_ch_scheduler.sv
// dma_ch_scheduler: round-robin descriptor-issue grant with per-channel outstanding counts and abort drain.
module dma_ch_scheduler #(
  parameter int NUM_CH    = 2,
  parameter int MAX_OUTST = 4,
  parameter int CNT_W     = 3
) (
  input  logic                             aclk,
  input  logic                             anreset,
  input  logic                             aenable,
  input  logic [NUM_CH-1:0]                i_ch_req,
  input  logic [NUM_CH-1:0]                i_abort,
  output logic                             o_grant_valid,
  output logic [1:0]                       o_grant_ch,
  input  logic                             i_grant_ready,
  input  logic                             i_resp_done,
  input  logic [1:0]                       i_resp_ch,
  output logic [NUM_CH-1:0][CNT_W-1:0]     o_outst_cnt,
  output logic [NUM_CH-1:0]                o_ch_busy,
  output logic [NUM_CH-1:0]                o_abort_done
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state_q, state_d;
  logic [1:0] ch_q, ch_d, last_q, last_d, win;
  logic [NUM_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_CH-1:0] drain_q, drain_d, done_q, done_d, elig, inc, dec, clr;
  logic found, hs, abort_cur;
  assign hs = (state_q == GRANT) && i_grant_ready;
  // Offsets are scanned from farthest to nearest so the nearest eligible channel after last_q wins.
  always_comb begin
    elig = '0;
    abort_cur = 1'b0;
    win = '0;
    found = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      elig[c] = i_ch_req[c] && !i_abort[c] && !drain_q[c] && (cnt_q[c] < CNT_W'(MAX_OUTST));
      if (ch_q == 2'(c)) abort_cur = i_abort[c];
    end
    for (int i = NUM_CH; i >= 1; i--)
      for (int c = 0; c < NUM_CH; c++)
        if (c == (int'(last_q) + i) % NUM_CH && elig[c]) begin
          win = 2'(c);
          found = 1'b1;
        end
  end
  always_comb begin
    state_d = state_q;
    ch_d = ch_q;
    last_d = last_q;
    if (state_q == IDLE) begin
      if (aenable && found) begin
        state_d = GRANT;
        ch_d = win;
      end
    end else if (hs || abort_cur) begin
      state_d = IDLE;
      last_d = hs ? ch_q : last_q;
    end
  end
  always_comb begin
    inc = '0;
    dec = '0;
    clr = '0;
    cnt_d = cnt_q;
    drain_d = drain_q;
    done_d = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      inc[c] = hs && (ch_q == 2'(c));
      dec[c] = i_resp_done && (i_resp_ch == 2'(c)) && (cnt_q[c] != '0);
      cnt_d[c] = (inc[c] && !dec[c]) ? cnt_q[c] + CNT_W'(1) :
                 (dec[c] && !inc[c]) ? cnt_q[c] - CNT_W'(1) : cnt_q[c];
      clr[c] = drain_q[c] && !i_abort[c] && (cnt_q[c] == '0);
      drain_d[c] = i_abort[c] || (drain_q[c] && !clr[c]);
      done_d[c] = clr[c];
    end
  end
  always_ff @(posedge aclk or negedge anreset) begin
    if (!anreset) begin
      state_q <= IDLE;
      ch_q <= '0;
      last_q <= 2'(NUM_CH - 1);
      cnt_q <= '0;
      drain_q <= '0;
      done_q <= '0;
    end else begin
      state_q <= state_d;
      ch_q <= ch_d;
      last_q <= last_d;
      cnt_q <= cnt_d;
      drain_q <= drain_d;
      done_q <= done_d;
    end
  end
  assign o_grant_valid = (state_q == GRANT);
  assign o_grant_ch = ch_q;
  assign o_outst_cnt = cnt_q;
  assign o_abort_done = done_q;
  always_comb
    for (int c = 0; c < NUM_CH; c++) o_ch_busy[c] = |cnt_q[c];
endmodule

// File: tb/tb_dma_ch_scheduler.sv
// tb_dma_ch_scheduler: directed vectors for grant order, backpressure, counters, abort drain and reset.
module tb_dma_ch_scheduler;
  logic aclk = 1'b0;
  logic anreset, aenable, ready, resp_done;
  logic [1:0] ch_req, abort, resp_ch, grant_ch, busy, done;
  logic valid;
  logic [1:0][2:0] cnt;
  int n_chk = 0;
  int n_fail = 0;
  dma_ch_scheduler #(.NUM_CH(2), .MAX_OUTST(4), .CNT_W(3)) dut (
    .aclk(aclk), .anreset(anreset), .aenable(aenable),
    .i_ch_req(ch_req), .i_abort(abort),
    .o_grant_valid(valid), .o_grant_ch(grant_ch), .i_grant_ready(ready),
    .i_resp_done(resp_done), .i_resp_ch(resp_ch),
    .o_outst_cnt(cnt), .o_ch_busy(busy), .o_abort_done(done)
  );
  always #5 aclk = ~aclk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask
  task automatic do_reset;
    anreset = 1'b0;
    aenable = 1'b1;
    ch_req = '0;
    abort = '0;
    ready = 1'b0;
    resp_done = 1'b0;
    resp_ch = '0;
    #12;
    @(negedge aclk);
    anreset = 1'b1;
    tick();
  endtask
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
  initial begin
    do_reset();
    chk("rst_valid", valid, 0);
    chk("rst_ch", grant_ch, 0);
    chk("rst_cnt0", cnt[0], 0);
    chk("rst_cnt1", cnt[1], 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    // alternation up to the outstanding limit
    ch_req = 2'b11;
    ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("alt_valid", valid, 1);
      chk("alt_ch", grant_ch, k % 2);
      tick();
      chk("alt_idle", valid, 0);
      chk("alt_cnt", (k % 2 == 0) ? cnt[0] : cnt[1], k / 2 + 1);
    end
    tick(3);
    chk("alt_full", valid, 0);
    chk("alt_busy", busy, 2'b11);
    // backpressure with aenable dropped mid-grant
    do_reset();
    ch_req = 2'b01;
    tick();
    chk("bp_valid", valid, 1);
    chk("bp_ch", grant_ch, 0);
    aenable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_hold_valid", valid, 1);
      chk("bp_hold_ch", grant_ch, 0);
      chk("bp_hold_cnt", cnt[0], 0);
    end
    ready = 1'b1;
    tick();
    chk("bp_acc_valid", valid, 0);
    chk("bp_acc_cnt", cnt[0], 1);
    tick(2);
    chk("en_low_block", valid, 0);
    chk("en_low_cnt", cnt[0], 1);
    aenable = 1'b1;
    ch_req = 2'b00;
    // simultaneous increment and decrement on ch1
    ch_req = 2'b10;
    tick(4);
    chk("sim_pre_cnt1", cnt[1], 2);
    tick();
    chk("sim_valid", valid, 1);
    chk("sim_ch", grant_ch, 1);
    resp_done = 1'b1;
    resp_ch = 2'd1;
    tick();
    ch_req = 2'b00;
    resp_done = 1'b0;
    chk("sim_cnt1", cnt[1], 2);
    chk("sim_idle", valid, 0);
    // spurious decrement and out-of-range channel
    resp_done = 1'b1;
    resp_ch = 2'd0;
    tick();
    chk("dec_cnt0", cnt[0], 0);
    tick();
    chk("spur_cnt0", cnt[0], 0);
    chk("spur_busy0", busy[0], 0);
    resp_ch = 2'd3;
    tick();
    chk("oor_cnt1", cnt[1], 2);
    resp_done = 1'b0;
    // abort drain on ch0 while ch1 keeps being granted
    ch_req = 2'b01;
    tick(6);
    chk("ab_pre_cnt0", cnt[0], 3);
    ch_req = 2'b11;
    abort = 2'b01;
    tick();
    chk("ab_g1_valid", valid, 1);
    chk("ab_g1_ch", grant_ch, 1);
    tick();
    chk("ab_cnt1", cnt[1], 3);
    abort = 2'b00;
    tick();
    chk("ab_g2_valid", valid, 1);
    chk("ab_g2_ch", grant_ch, 1);
    tick(2);
    chk("ab_blocked", valid, 0);
    chk("ab_cnt1_full", cnt[1], 4);
    resp_done = 1'b1;
    resp_ch = 2'd0;
    tick(2);
    chk("ab_drain_cnt0", cnt[0], 1);
    chk("ab_drain_done", done, 0);
    tick();
    resp_done = 1'b0;
    chk("ab_zero_cnt0", cnt[0], 0);
    chk("ab_zero_done", done, 0);
    tick();
    chk("ab_done_pulse", done, 2'b01);
    chk("ab_done_valid", valid, 0);
    tick();
    chk("ab_done_clear", done, 0);
    chk("ab_regrant_valid", valid, 1);
    chk("ab_regrant_ch", grant_ch, 0);
    ch_req = 2'b00;
    tick();
    chk("ab_regrant_cnt0", cnt[0], 1);
    // grant withdrawal on abort
    do_reset();
    ch_req = 2'b01;
    tick();
    chk("wd_valid", valid, 1);
    abort = 2'b01;
    tick();
    chk("wd_drop", valid, 0);
    chk("wd_cnt0", cnt[0], 0);
    abort = 2'b00;
    ch_req = 2'b00;
    tick();
    chk("wd_done", done, 2'b01);
    tick();
    chk("wd_done_clear", done, 0);
    // asynchronous reset mid-operation
    do_reset();
    ch_req = 2'b11;
    ready = 1'b1;
    tick(8);
    ch_req = 2'b10;
    tick(2);
    chk("mr_cnt0", cnt[0], 2);
    chk("mr_cnt1", cnt[1], 3);
    ch_req = 2'b11;
    ready = 1'b0;
    tick();
    chk("mr_pend", valid, 1);
    #2 anreset = 1'b0;
    #1;
    chk("mr_valid", valid, 0);
    chk("mr_ch", grant_ch, 0);
    chk("mr_rcnt0", cnt[0], 0);
    chk("mr_rcnt1", cnt[1], 0);
    chk("mr_busy", busy, 0);
    @(negedge aclk);
    anreset = 1'b1;
    ready = 1'b1;
    tick();
    chk("mr_first_valid", valid, 1);
    chk("mr_first_ch", grant_ch, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
